// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter that multiplexes four byte streams onto one
// 8N1 transmitter. The owner keeps the transmitter for up to MAX_BURST bytes.
// The owner is also released when its message ends, its request drops, or the
// transmitter stops answering.
module uart_tx_arbiter #(
  parameter int unsigned MAX_BURST  = 16,
  parameter logic [15:0] TX_TIMEOUT = 16'd2000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [3:0]  req,
  input  logic [31:0] req_byte,
  input  logic [3:0]  req_last,
  output logic [3:0]  ack,
  output logic [3:0]  grant,
  output logic        tx_senddata,
  output logic [7:0]  tx_byte,
  input  logic        tx_done,
  output logic        busy,
  output logic        err_timeout,
  input  logic        err_clr
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    WAIT = 2'd2
  } state_t;

  localparam logic [7:0] MAX_BURST_C = 8'(MAX_BURST);

  state_t      state_q, state_d;
  logic [1:0]  owner_q, owner_d;
  logic [1:0]  last_owner_q, last_owner_d;
  logic [3:0]  grant_q, grant_d;
  logic [3:0]  ack_q, ack_d;
  logic        tx_send_q, tx_send_d;
  logic [7:0]  tx_byte_q, tx_byte_d;
  logic        last_q, last_d;
  logic [7:0]  burst_q, burst_d;
  logic [15:0] wait_cnt_q, wait_cnt_d;
  logic        busy_q, busy_d;
  logic        err_q, err_d;

  logic [1:0]  rr_pick;
  logic [1:0]  rr_cand;
  logic        rr_found;
  logic        rel_now;
  logic        timeout_hit;

  // Round-robin search: first requester at or after last_owner+1, wrapping mod 4
  always_comb begin
    rr_pick  = last_owner_q + 2'd1;
    rr_cand  = last_owner_q + 2'd1;
    rr_found = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      rr_cand = last_owner_q + 2'(i);
      if (!rr_found && req[rr_cand]) begin
        rr_pick  = rr_cand;
        rr_found = 1'b1;
      end
    end
  end

  // Next-state and next-output computation for the IDLE/LOAD/WAIT controller
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    grant_d      = grant_q;
    ack_d        = 4'b0000;
    tx_send_d    = 1'b0;
    tx_byte_d    = tx_byte_q;
    last_d       = last_q;
    burst_d      = burst_q;
    wait_cnt_d   = wait_cnt_q;
    err_d        = err_q;
    rel_now      = 1'b0;
    timeout_hit  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (|req) begin
          owner_d = rr_pick;
          grant_d = 4'b0001 << rr_pick;
          state_d = LOAD;
        end
      end
      LOAD: begin
        tx_byte_d  = req_byte[{owner_q, 3'b000} +: 8];
        tx_send_d  = 1'b1;
        ack_d      = 4'b0001 << owner_q;
        last_d     = req_last[owner_q];
        burst_d    = (burst_q == 8'hFF) ? burst_q : burst_q + 8'd1;
        wait_cnt_d = 16'd0;
        state_d    = WAIT;
      end
      WAIT: begin
        if (tx_done) begin
          if (last_q || (burst_q == MAX_BURST_C) || !req[owner_q]) begin
            rel_now = 1'b1;
          end else begin
            state_d = LOAD;
          end
        end else if (({1'b0, wait_cnt_q} + 17'd1) >= {1'b0, TX_TIMEOUT}) begin
          timeout_hit = 1'b1;
          rel_now     = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 16'd1;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = 4'b0000;
      end
    endcase

    if (rel_now) begin
      grant_d      = 4'b0000;
      last_owner_d = owner_q;
      burst_d      = 8'd0;
      wait_cnt_d   = 16'd0;
      state_d      = IDLE;
    end

    // A timeout that lands together with a clear request must stay visible
    if (err_clr) begin
      err_d = 1'b0;
    end
    if (timeout_hit) begin
      err_d = 1'b1;
    end

    busy_d = (state_d != IDLE);
  end

  // State and output registers; last_owner resets to 3 so requester 0 wins first
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= IDLE;
      owner_q      <= 2'd0;
      last_owner_q <= 2'd3;
      grant_q      <= 4'b0000;
      ack_q        <= 4'b0000;
      tx_send_q    <= 1'b0;
      tx_byte_q    <= 8'h00;
      last_q       <= 1'b0;
      burst_q      <= 8'd0;
      wait_cnt_q   <= 16'd0;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      grant_q      <= grant_d;
      ack_q        <= ack_d;
      tx_send_q    <= tx_send_d;
      tx_byte_q    <= tx_byte_d;
      last_q       <= last_d;
      burst_q      <= burst_d;
      wait_cnt_q   <= wait_cnt_d;
      busy_q       <= busy_d;
      err_q        <= err_d;
    end
  end

  assign ack         = ack_q;
  assign grant       = grant_q;
  assign tx_senddata = tx_send_q;
  assign tx_byte     = tx_byte_q;
  assign busy        = busy_q;
  assign err_timeout = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: requesters are modelled as byte queues and the transmitter
// as a tx_done responder with random latency. Every grant, byte, ack and release
// is predicted from the round-robin, burst, message-end and timeout rules.
module tb_uart_tx_arbiter;

  localparam int MaxBurst  = 3;
  localparam int TxTimeout = 20;

  logic        clk = 1'b0;
  logic        resetn;
  logic [3:0]  req;
  logic [31:0] req_byte;
  logic [3:0]  req_last;
  logic [3:0]  ack;
  logic [3:0]  grant;
  logic        tx_senddata;
  logic [7:0]  tx_byte;
  logic        tx_done;
  logic        busy;
  logic        err_timeout;
  logic        err_clr;

  int checks = 0;
  int errors = 0;

  logic [8:0] fifo [4][64];
  int  head [4];
  int  tail [4];
  bit  paused [4];
  int  lastOwner;
  bit  errExp;
  bit  allowFaults;
  int  forceAction;

  uart_tx_arbiter #(
    .MAX_BURST  (MaxBurst),
    .TX_TIMEOUT (16'(TxTimeout))
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .req         (req),
    .req_byte    (req_byte),
    .req_last    (req_last),
    .ack         (ack),
    .grant       (grant),
    .tx_senddata (tx_senddata),
    .tx_byte     (tx_byte),
    .tx_done     (tx_done),
    .busy        (busy),
    .err_timeout (err_timeout),
    .err_clr     (err_clr)
  );

  always #5 clk = ~clk;

  // Single comparison point; counts every check and reports any mismatch
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Requester i asserts req while it has bytes queued and has not withdrawn
  task automatic updateDrivers();
    for (int i = 0; i < 4; i++) begin
      logic [8:0] h;
      h = (head[i] < tail[i]) ? fifo[i][head[i]] : 9'h000;
      req[i]             = (head[i] < tail[i]) && !paused[i];
      req_byte[8*i +: 8] = h[7:0];
      req_last[i]        = h[8];
    end
  endtask

  task automatic pushMsg(input int r, input int len, input bit randomBytes, input logic [7:0] base);
    for (int k = 0; k < len; k++) begin
      logic [7:0] b;
      b = randomBytes ? 8'($urandom) : base + 8'(k);
      if (tail[r] < 64) begin
        fifo[r][tail[r]] = {(k == len - 1), b};
        tail[r]++;
      end
    end
  endtask

  function automatic int pickOwner(input int prev, input logic [3:0] r);
    for (int k = 1; k <= 4; k++) begin
      if (r[(prev + k) % 4]) return (prev + k) % 4;
    end
    return 0;
  endfunction

  // Load a fresh set of messages; the first rounds are the directed scenarios
  task automatic applyStimulus(input int round);
    for (int i = 0; i < 4; i++) begin
      head[i]   = 0;
      tail[i]   = 0;
      paused[i] = 0;
    end
    allowFaults = 0;
    forceAction = -1;
    case (round)
      0: begin
        pushMsg(0, 1, 0, 8'h10);
        pushMsg(1, 1, 0, 8'h11);
        pushMsg(2, 1, 0, 8'h12);
        pushMsg(3, 1, 0, 8'h13);
        pushMsg(0, 1, 0, 8'h14);
      end
      1: begin
        pushMsg(2, 3, 0, 8'hA0);
        pushMsg(0, 1, 0, 8'h55);
      end
      2: begin
        pushMsg(1, 5, 0, 8'hB0);
        pushMsg(3, 1, 0, 8'hC0);
      end
      3: begin
        pushMsg(0, 1, 0, 8'h41);
        forceAction = 0;
      end
      4: begin
        pushMsg(2, 1, 0, 8'hD0);
        pushMsg(2, 1, 0, 8'hD1);
        forceAction = 1;
      end
      default: begin
        allowFaults = 1;
        for (int i = 0; i < 4; i++) begin
          if ($urandom_range(0, 1) == 1) begin
            int nMsg;
            nMsg = int'($urandom_range(1, 2));
            for (int m = 0; m < nMsg; m++) pushMsg(i, int'($urandom_range(1, 4)), 1, 8'h00);
          end
        end
      end
    endcase
    updateDrivers();
  endtask

  // One grant from IDLE through to release; entered on a negedge with the DUT idle
  task automatic runService();
    int owner, burst, action, dly;
    logic [3:0] oh;
    logic [7:0] expByte;
    bit lastFlag, done, relExp;

    owner = pickOwner(lastOwner, req);
    oh    = 4'(1 << owner);
    @(negedge clk);
    checkOutput("grant_onehot", 32'(grant), 32'(oh));
    checkOutput("busy_on_grant", 32'(busy), 32'd1);
    checkOutput("senddata_idle", 32'(tx_senddata), 32'd0);
    checkOutput("err_timeout_level", 32'(err_timeout), 32'(errExp));
    tx_done = allowFaults && ($urandom_range(0, 3) == 0);
    burst = 0;
    done  = 0;
    while (!done) begin
      @(negedge clk);
      tx_done = 0;
      checkOutput("senddata_pulse", 32'(tx_senddata), 32'd1);
      checkOutput("ack_owner", 32'(ack), 32'(oh));
      expByte  = fifo[owner][head[owner]][7:0];
      lastFlag = fifo[owner][head[owner]][8];
      checkOutput("tx_byte", 32'(tx_byte), 32'(expByte));
      head[owner]++;
      burst++;
      if (forceAction >= 0) begin
        action      = forceAction;
        forceAction = -1;
      end else begin
        action = allowFaults ? int'($urandom_range(0, 19)) : 99;
      end
      if (action == 2) paused[owner] = 1;
      updateDrivers();

      if (action == 0) begin
        for (int j = 1; j < TxTimeout; j++) begin
          @(negedge clk);
          checkOutput("busy_waiting", 32'(busy), 32'd1);
          if (j == 1) checkOutput("senddata_single", 32'(tx_senddata), 32'd0);
          if (j == TxTimeout - 1) checkOutput("err_before_limit", 32'(err_timeout), 32'(errExp));
        end
        err_clr = 1'($urandom_range(0, 1));
        @(negedge clk);
        err_clr = 0;
        errExp  = 1;
        checkOutput("err_set_on_timeout", 32'(err_timeout), 32'd1);
        checkOutput("grant_after_timeout", 32'(grant), 32'd0);
        checkOutput("busy_after_timeout", 32'(busy), 32'd0);
        checkOutput("no_ack_on_abort", 32'(ack), 32'd0);
        lastOwner = owner;
        done      = 1;
      end else if (action == 1) begin
        dly = int'($urandom_range(0, 5));
        repeat (dly) @(negedge clk);
        resetn = 0;
        @(negedge clk);
        resetn = 1;
        checkOutput("grant_after_reset", 32'(grant), 32'd0);
        checkOutput("busy_after_reset", 32'(busy), 32'd0);
        checkOutput("senddata_after_reset", 32'(tx_senddata), 32'd0);
        checkOutput("ack_after_reset", 32'(ack), 32'd0);
        checkOutput("tx_byte_after_reset", 32'(tx_byte), 32'd0);
        checkOutput("err_after_reset", 32'(err_timeout), 32'd0);
        lastOwner = 3;
        errExp    = 0;
        done      = 1;
      end else begin
        dly = int'($urandom_range(0, 10));
        for (int j = 0; j < dly; j++) begin
          @(negedge clk);
          checkOutput("senddata_single", 32'(tx_senddata), 32'd0);
          checkOutput("ack_single", 32'(ack), 32'd0);
          checkOutput("tx_byte_stable", 32'(tx_byte), 32'(expByte));
          checkOutput("grant_held", 32'(grant), 32'(oh));
        end
        relExp  = lastFlag || (burst == MaxBurst) || !req[owner];
        tx_done = 1;
        @(negedge clk);
        tx_done = 0;
        checkOutput("ack_after_done", 32'(ack), 32'd0);
        checkOutput("senddata_after_done", 32'(tx_senddata), 32'd0);
        if (relExp) begin
          checkOutput("grant_released", 32'(grant), 32'd0);
          checkOutput("busy_released", 32'(busy), 32'd0);
          lastOwner = owner;
          done      = 1;
        end else begin
          checkOutput("grant_kept", 32'(grant), 32'(oh));
          checkOutput("busy_kept", 32'(busy), 32'd1);
        end
      end
    end
    for (int i = 0; i < 4; i++) paused[i] = 0;
    updateDrivers();
  endtask

  initial begin
    resetn   = 0;
    req      = 4'b0000;
    req_byte = 32'h0;
    req_last = 4'b0000;
    tx_done  = 0;
    err_clr  = 0;
    lastOwner   = 3;
    errExp      = 0;
    allowFaults = 0;
    forceAction = -1;
    for (int i = 0; i < 4; i++) begin
      head[i]   = 0;
      tail[i]   = 0;
      paused[i] = 0;
    end
    repeat (2) @(negedge clk);
    checkOutput("reset_grant", 32'(grant), 32'd0);
    checkOutput("reset_ack", 32'(ack), 32'd0);
    checkOutput("reset_senddata", 32'(tx_senddata), 32'd0);
    checkOutput("reset_tx_byte", 32'(tx_byte), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_err", 32'(err_timeout), 32'd0);
    resetn = 1;
    @(negedge clk);
    checkOutput("idle_no_req", 32'(busy), 32'd0);

    for (int r = 0; r < 40; r++) begin
      int guard;
      applyStimulus(r);
      guard = 0;
      while (req != 4'b0000 && guard < 200) begin
        runService();
        guard++;
      end
      tx_done = 1;
      @(negedge clk);
      tx_done = 0;
      checkOutput("idle_ignores_done_busy", 32'(busy), 32'd0);
      checkOutput("idle_ignores_done_grant", 32'(grant), 32'd0);
      checkOutput("idle_err_level", 32'(err_timeout), 32'(errExp));
      if (errExp) begin
        err_clr = 1;
        @(negedge clk);
        err_clr = 0;
        errExp  = 0;
        checkOutput("err_cleared", 32'(err_timeout), 32'd0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
